// File: rtl/reflex_round_sequencer.sv
// reflex_round_sequencer: multi-round game controller for the reflex game.
// Sequences LOAD -> PLAY -> RESULT -> GAP per round, keeps score and
// measures reaction time. Optional macro REFLEX_BEST_TIME_EN adds tracking
// of the best reaction time per game; without it best_time is all-ones.

module reflex_round_sequencer #(
    parameter int NUM_ROUNDS    = 4,
    parameter int PLAY_CYCLES   = 199,
    parameter int RESULT_CYCLES = 10,
    parameter int GAP_CYCLES    = 4,
    parameter int TIME_W        = 8,
    localparam int ROUND_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    localparam int SCORE_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         code,
    input  logic               match,
    output logic               lfsr_en,
    output logic               code_load,
    output logic               play_active,
    output logic [ROUND_W-1:0] round_idx,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  reaction_time,
    output logic [TIME_W-1:0]  best_time,
    output logic               correct_light,
    output logic               incorrect_light,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_RESULT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TIME_W-1:0]  timer_q, timer_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TIME_W-1:0]  react_q, react_d;
    logic               start_q, start_d;

    logic               start_edge;
    logic               last_hit;
    logic               game_start;
    logic               round_hit;

    assign start_edge = start & ~start_q;
    // A correct round stores a timer value below PLAY_CYCLES, which can never
    // be all-ones, so the stored reaction time doubles as the hit/miss flag.
    assign last_hit   = (react_q != '1);

    assign round_idx     = round_q;
    assign score         = score_q;
    assign reaction_time = react_q;

    // Next-state, datapath updates and Moore output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        round_d         = round_q;
        score_d         = score_q;
        react_d         = react_q;
        start_d         = start;
        game_start      = 1'b0;
        round_hit       = 1'b0;
        lfsr_en         = 1'b1;
        code_load       = 1'b0;
        play_active     = 1'b0;
        correct_light   = 1'b0;
        incorrect_light = 1'b0;
        game_over       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) game_start = 1'b1;
            end
            S_LOAD: begin
                // A zero code is unusable: keep stepping the LFSR and retry.
                if (code != 8'h00) begin
                    code_load = 1'b1;
                    lfsr_en   = 1'b0;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                lfsr_en     = 1'b0;
                play_active = 1'b1;
                // The player's lights lag code_load by one cycle, so a match
                // seen at timer 0 reflects the previous code and is ignored.
                if (match && (timer_q != '0)) begin
                    round_hit = 1'b1;
                    score_d   = score_q + SCORE_W'(1);
                    react_d   = timer_q;
                    state_d   = S_RESULT;
                end else if (timer_q == TIME_W'(PLAY_CYCLES - 1)) begin
                    react_d = '1;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                correct_light   = last_hit;
                incorrect_light = ~last_hit;
                if (timer_q == TIME_W'(RESULT_CYCLES - 1)) begin
                    if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (timer_q == TIME_W'(GAP_CYCLES - 1)) state_d = S_LOAD;
            end
            S_DONE: begin
                game_over = 1'b1;
                if (start_edge) game_start = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (game_start) begin
            state_d = S_LOAD;
            round_d = '0;
            score_d = '0;
        end

        // The phase timer restarts on every state change and idles at zero.
        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIME_W'(1);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            round_q <= '0;
            score_q <= '0;
            react_q <= '1;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            round_q <= round_d;
            score_q <= score_d;
            react_q <= react_d;
            start_q <= start_d;
        end
    end

`ifdef REFLEX_BEST_TIME_EN
    logic [TIME_W-1:0] best_q, best_d;

    // Best time: cleared at game start, lowered on each faster correct round.
    always_comb begin
        best_d = best_q;
        if (game_start) begin
            best_d = '1;
        end else if (round_hit && (timer_q < best_q)) begin
            best_d = timer_q;
        end
    end

    // Best-time register.
    always_ff @(posedge clock) begin
        if (reset) best_q <= '1;
        else       best_q <= best_d;
    end

    assign best_time = best_q;
`else
    assign best_time = '1;
`endif

endmodule

// File: tb/tb_reflex_round_sequencer.sv
// Self-checking bench for reflex_round_sequencer: randomized codes and match
// noise, directed round outcomes, and a game-level reference model compared
// against every output on every cycle after the first reset.

module tb_reflex_round_sequencer;

    localparam int NR = 4;
    localparam int PC = 199;
    localparam int RC = 10;
    localparam int GC = 4;
    localparam int TW = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] code;
    logic       match;
    logic       lfsr_en;
    logic       code_load;
    logic       play_active;
    logic [1:0] round_idx;
    logic [2:0] score;
    logic [7:0] reaction_time;
    logic [7:0] best_time;
    logic       correct_light;
    logic       incorrect_light;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int zero_left = 0;

    reflex_round_sequencer #(
        .NUM_ROUNDS(NR), .PLAY_CYCLES(PC), .RESULT_CYCLES(RC),
        .GAP_CYCLES(GC), .TIME_W(TW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .code(code), .match(match),
        .lfsr_en(lfsr_en), .code_load(code_load), .play_active(play_active),
        .round_idx(round_idx), .score(score), .reaction_time(reaction_time),
        .best_time(best_time), .correct_light(correct_light),
        .incorrect_light(incorrect_light), .game_over(game_over)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model (game-level view) ----------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_RESULT = 3, P_GAP = 4, P_DONE = 5;

    bit model_valid = 1'b0;
    int m_phase, m_elapsed, m_left, m_round, m_score, m_rt, m_best;
    bit m_hit, m_start_prev, m_edge;

    always @(posedge clock) begin
        if (reset) begin
            m_phase      = P_IDLE;
            m_round      = 0;
            m_score      = 0;
            m_rt         = 255;
            m_best       = 255;
            m_hit        = 1'b0;
            m_start_prev = 1'b1;
            model_valid  = 1'b1;
        end else if (model_valid) begin
            m_edge       = start && !m_start_prev;
            m_start_prev = start;
            case (m_phase)
                P_IDLE, P_DONE: if (m_edge) begin
                    m_phase = P_LOAD; m_round = 0; m_score = 0; m_best = 255;
                end
                P_LOAD: if (code != 8'h00) begin
                    m_phase = P_PLAY; m_elapsed = 0;
                end
                P_PLAY: begin
                    if (m_elapsed >= 1 && match) begin
                        m_hit = 1'b1; m_score++; m_rt = m_elapsed;
`ifdef REFLEX_BEST_TIME_EN
                        if (m_elapsed < m_best) m_best = m_elapsed;
`endif
                        m_phase = P_RESULT; m_left = RC;
                    end else if (m_elapsed == PC - 1) begin
                        m_hit = 1'b0; m_rt = 255;
                        m_phase = P_RESULT; m_left = RC;
                    end else begin
                        m_elapsed++;
                    end
                end
                P_RESULT: begin
                    if (m_left == 1) begin
                        if (m_round == NR - 1) m_phase = P_DONE;
                        else begin m_round++; m_phase = P_GAP; m_left = GC; end
                    end else m_left--;
                end
                P_GAP: begin
                    if (m_left == 1) m_phase = P_LOAD;
                    else m_left--;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clock) begin
        if (model_valid) begin
            check("lfsr_en", lfsr_en, (m_phase == P_PLAY) ? 0 : (m_phase == P_LOAD) ? (code == 8'h00) : 1);
            check("code_load", code_load, (m_phase == P_LOAD) && (code != 8'h00));
            check("play_active", play_active, m_phase == P_PLAY);
            check("correct_light", correct_light, (m_phase == P_RESULT) && m_hit);
            check("incorrect_light", incorrect_light, (m_phase == P_RESULT) && !m_hit);
            check("game_over", game_over, m_phase == P_DONE);
            check("round_idx", round_idx, m_round);
            check("score", score, m_score);
            check("reaction_time", reaction_time, m_rt);
            check("best_time", best_time, m_best);
        end
    end

    // ---------------- Stimulus ----------------
    // NOTE: inputs change 2 ns after the active edge and outputs are read
    // 1 ns later, so neither the DUT nor the checker races the clock.
    task automatic tick();
        @(posedge clock);
        #2;
        if (zero_left > 0) begin
            code = 8'h00;
            zero_left--;
        end else begin
            code = 8'($urandom_range(1, 255));
        end
        #1;
    endtask

    task automatic play_round(input int hit_t, input bit zero_poke, input bit start_poke,
                              input int abort_at, output int plays, output int n_cor,
                              output int n_inc);
        int guard;
        int t;
        plays = 0; n_cor = 0; n_inc = 0;
        guard = 0;
        while (!play_active && guard < 100) begin
            match = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("play_wait_bound", guard < 100, 1);
        t = 0;
        while (play_active && t < PC + 5) begin
            match = (t == 0) ? zero_poke : (t == hit_t);
            if (start_poke) start = (t >= 5 && t < 8);
            plays++;
            tick();
            t++;
        end
        match = 1'b0;
        if (start_poke) start = 1'b0;
        guard = 0;
        while ((correct_light || incorrect_light) && guard < RC + 5) begin
            if (guard == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                return;
            end
            n_cor += int'(correct_light);
            n_inc += int'(incorrect_light);
            match = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        match = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    int plays, n_cor, n_inc, zc, idle_loads;
    int hit_list[4];

    initial begin
        reset = 1'b1; start = 1'b1; match = 1'b0; code = 8'h5A;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_score", score, 0);
        check("rst_rt", reaction_time, 8'hFF);
        check("rst_best", best_time, 8'hFF);
        check("rst_lfsr", lfsr_en, 1);

        // Start held high through and after reset must not start a game.
        idle_loads = 0;
        repeat (20) begin
            tick();
            idle_loads += int'(code_load || play_active || game_over);
        end
        check("idle_held_start", idle_loads, 0);
        check("idle_lfsr", lfsr_en, 1);

        // Game 1: code_load exactly one cycle, one cycle after the edge.
        start_pulse();
        check("cl_latency", code_load, 1);
        start = 1'b0;
        tick();
        check("cl_width", code_load, 0);
        check("play_begins", play_active, 1);

        play_round(37, 1'b1, 1'b0, -1, plays, n_cor, n_inc);
        check("r0_cor_cycles", n_cor, 10);
        check("r0_inc_cycles", n_inc, 0);
        check("r0_score", score, 1);
        check("r0_rt", reaction_time, 37);
        check("r0_round_idx", round_idx, 1);
        check("model_r0_rt", m_rt, 37);

        play_round(-1, 1'b0, 1'b0, -1, plays, n_cor, n_inc);
        check("miss_play_cycles", plays, 199);
        check("miss_inc_cycles", n_inc, 10);
        check("miss_cor_cycles", n_cor, 0);
        check("miss_score", score, 1);
        check("miss_rt", reaction_time, 8'hFF);

        play_round(50, 1'b0, 1'b1, -1, plays, n_cor, n_inc);
        check("poke_score", score, 2);
        play_round(20, 1'b0, 1'b0, -1, plays, n_cor, n_inc);
        check("g1_game_over", game_over, 1);
        check("g1_score", score, 3);
        repeat (5) begin match = 1'($urandom_range(0, 1)); tick(); end
        match = 1'b0;
        check("g1_held", game_over, 1);

        // Game 2: start in DONE, zero code for three LOAD cycles.
        start = 1'b0;
        tick();
        start = 1'b1;
        zero_left = 3;
        tick();
        check("g2_score_clr", score, 0);
        check("g2_round_clr", round_idx, 0);
        zc = 0;
        while (!code_load && zc < 10) begin
            zc += int'(lfsr_en && !play_active);
            tick();
        end
        check("zero_retry_cycles", zc, 3);
        check("zero_then_load", code_load, 1);
        start = 1'b0;

        play_round(50, 1'b0, 1'b0, -1, plays, n_cor, n_inc);
        play_round(20, 1'b0, 1'b0, -1, plays, n_cor, n_inc);
        play_round(90, 1'b0, 1'b0, -1, plays, n_cor, n_inc);
        play_round(PC - 1, 1'b0, 1'b0, -1, plays, n_cor, n_inc);
        check("final_cycle_hit", n_cor, 10);
        check("final_cycle_rt", reaction_time, PC - 1);
        check("g2_score", score, 4);
`ifdef REFLEX_BEST_TIME_EN
        check("g2_best", best_time, 20);
`else
        check("g2_best", best_time, 8'hFF);
`endif

        // Game 3: randomized outcomes.
        start_pulse();
        start = 1'b0;
        for (int r = 0; r < NR; r++) begin
            hit_list[r] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, PC - 1));
            play_round(hit_list[r], 1'($urandom_range(0, 1)), 1'b0, -1, plays, n_cor, n_inc);
            check("g3_light_cycles", n_cor + n_inc, 10);
        end
        check("g3_done", game_over, 1);

        // Game 4: reset in the middle of RESULT.
        start_pulse();
        start = 1'b0;
        play_round(15, 1'b0, 1'b0, 3, plays, n_cor, n_inc);
        check("abort_cor_cycles", n_cor, 3);
        check("abort_cor_light", correct_light, 0);
        check("abort_inc_light", incorrect_light, 0);
        check("abort_score", score, 0);
        check("abort_round", round_idx, 0);
        check("abort_rt", reaction_time, 8'hFF);
        check("abort_lfsr", lfsr_en, 1);
        repeat (5) tick();
        check("abort_idle", play_active || code_load || game_over, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
